// File: rtl/alu_program_sequencer.sv
// ---------------------------------------------------------------------------
// alu_program_sequencer
//
// Instruction-side driver for the 12-bit accumulator ALU. Holds a loadable
// program, issues one instruction per clock, captures ALU results into an
// output FIFO and stops when the ALU halts or the last program entry has
// been issued. The only stall mechanism is re-presenting the current
// OUT/HALT instruction, which has no side effects inside the ALU.
//
// Optional feature macro: SEQ_CYCLE_COUNT_EN
//   defined   -> o_cycle_count counts RUN cycles (stalls included), cleared on
//                RUN entry, held outside RUN, saturating at 2^32-1
//   undefined -> o_cycle_count is tied to zero
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_prog_we/addr/data   program memory write port (ignored while running)
//   i_start               begin execution at address 0 (ignored while running)
//   o_busy, o_done        sequencer in RUN / in DONE
//   o_overrun             last entry executed without a HALT
//   o_alu_instruction     registered instruction presented to the ALU
//   i_alu_out_data/valid  ALU result for the current instruction
//   i_alu_halt            ALU halt for the current instruction
//   o_res_data/valid      result FIFO head / FIFO non-empty
//   i_res_ready           pop FIFO head when o_res_valid is high
//   o_res_count           result FIFO occupancy
//   o_cycle_count         RUN cycle counter (see macro above)
// ---------------------------------------------------------------------------
module alu_program_sequencer #(
  parameter int DATA_WIDTH  = 12,
  parameter int INSTR_WIDTH = 12,
  parameter int PROG_DEPTH  = 64,
  parameter int OUT_DEPTH   = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0]  i_prog_addr,
  input  logic [INSTR_WIDTH-1:0]         i_prog_data,
  input  logic                           i_start,
  output logic                           o_busy,
  output logic                           o_done,
  output logic                           o_overrun,
  output logic [INSTR_WIDTH-1:0]         o_alu_instruction,
  input  logic [DATA_WIDTH-1:0]          i_alu_out_data,
  input  logic                           i_alu_out_valid,
  input  logic                           i_alu_halt,
  output logic [DATA_WIDTH-1:0]          o_res_data,
  output logic                           o_res_valid,
  input  logic                           i_res_ready,
  output logic [$clog2(OUT_DEPTH):0]     o_res_count,
  output logic [31:0]                    o_cycle_count
);

  localparam int PA = $clog2(PROG_DEPTH);
  localparam int OA = $clog2(OUT_DEPTH);
  localparam int CW = OA + 1;
  // OUT R0: harmless filler presented to the ALU whenever nothing runs
  localparam logic [INSTR_WIDTH-1:0] IDLE_INSTR = INSTR_WIDTH'(12'hC00);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PA-1:0]           r_ia;
  logic [PA-1:0]           w_ia_nxt;
  logic [PA-1:0]           w_ia_plus;
  logic [INSTR_WIDTH-1:0]  r_instr;
  logic [INSTR_WIDTH-1:0]  w_instr_nxt;
  logic                    r_overrun;
  logic                    w_overrun_nxt;

  logic [INSTR_WIDTH-1:0]  r_mem [PROG_DEPTH];
  logic                    w_prog_wr;
  logic [INSTR_WIDTH-1:0]  w_mem0;

  logic [DATA_WIDTH-1:0]   r_fifo [OUT_DEPTH];
  logic [OA-1:0]           r_wptr;
  logic [OA-1:0]           r_rptr;
  logic [CW-1:0]           r_count;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_stall;

  assign w_prog_wr = i_prog_we && (r_state != ST_RUN);
  assign w_ia_plus = r_ia + PA'(1);

  // A write to address 0 in the same cycle as start must be what RUN sees
  // first, so bypass the memory for that one case.
  assign w_mem0 = (w_prog_wr && (i_prog_addr == '0)) ? i_prog_data : r_mem[0];

  assign w_pop = i_res_ready && (r_count != '0);

  // Program memory: plain register file, deliberately untouched by reset so a
  // loaded program survives an abort.
  always_ff @(posedge i_clk) begin
    if (w_prog_wr) begin
      r_mem[i_prog_addr] <= i_prog_data;
    end
  end

  // Next-state logic. A full FIFO with a pending result freezes the issue
  // pointer; a pop in that same cycle does not rescue the push because the
  // decision is made against the registered occupancy.
  always_comb begin
    w_state_nxt   = r_state;
    w_instr_nxt   = r_instr;
    w_ia_nxt      = r_ia;
    w_overrun_nxt = r_overrun;
    w_push        = 1'b0;
    w_stall       = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        w_instr_nxt = IDLE_INSTR;
        if (i_start) begin
          w_state_nxt   = ST_RUN;
          w_instr_nxt   = w_mem0;
          w_ia_nxt      = '0;
          w_overrun_nxt = 1'b0;
        end
      end
      ST_RUN: begin
        if (i_alu_out_valid && (r_count == CW'(OUT_DEPTH))) begin
          w_stall = 1'b1;
        end else begin
          w_push = i_alu_out_valid;
          if (i_alu_halt) begin
            w_state_nxt = ST_DONE;
            w_instr_nxt = IDLE_INSTR;
          end else if (r_ia == PA'(PROG_DEPTH - 1)) begin
            w_state_nxt   = ST_DONE;
            w_overrun_nxt = 1'b1;
            w_instr_nxt   = IDLE_INSTR;
          end else begin
            w_instr_nxt = r_mem[w_ia_plus];
            w_ia_nxt    = w_ia_plus;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_instr_nxt = IDLE_INSTR;
      end
    endcase
  end

  // Sequencer state register; reset aborts a run immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_ia      <= '0;
      r_instr   <= IDLE_INSTR;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ia      <= w_ia_nxt;
      r_instr   <= w_instr_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Result FIFO storage; contents are meaningless while the count is zero,
  // so only the pointers need reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= i_alu_out_data;
    end
  end

  // Result FIFO pointers and occupancy. Pointers wrap naturally because the
  // depth is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + OA'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + OA'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef SEQ_CYCLE_COUNT_EN
  logic [31:0] r_cycle_count;

  // RUN-cycle counter: restarts on each run entry, counts stalled cycles
  // too, and sticks at all-ones rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cycle_count <= '0;
    end else if ((r_state != ST_RUN) && i_start) begin
      r_cycle_count <= '0;
    end else if ((r_state == ST_RUN) && (r_cycle_count != '1)) begin
      r_cycle_count <= r_cycle_count + 32'd1;
    end
  end

  assign o_cycle_count = r_cycle_count;
`else
  assign o_cycle_count = '0;
`endif

  assign o_busy            = (r_state == ST_RUN);
  assign o_done            = (r_state == ST_DONE);
  assign o_overrun         = r_overrun;
  assign o_alu_instruction = r_instr;
  assign o_res_data        = r_fifo[r_rptr];
  assign o_res_valid       = (r_count != '0);
  assign o_res_count       = r_count;

endmodule

// File: tb/tb_alu_program_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_program_sequencer
//
// Self-checking bench for alu_program_sequencer. A small behavioural ALU
// (opcode = instr[11:8]) is attached to the sequencer:
//   1 LL   Rd,#imm6   Rd = imm                (Rd = instr[7:6])
//   2 ADD  Rd,Rs      Rd = Rd + Rs            (Rs = instr[5:4])
//   C OUT  Rd         result = Rd
//   F HALT Rd         result = Rd, halt
//   others            no operation
// Expected results come from an instruction-level program interpreter.
// Honours SEQ_CYCLE_COUNT_EN for the cycle counter expectations.
// ---------------------------------------------------------------------------
module tb_alu_program_sequencer;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_prog_we;
  logic [5:0]  i_prog_addr;
  logic [11:0] i_prog_data;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic        o_overrun;
  logic [11:0] o_alu_instruction;
  logic [11:0] aluData;
  logic        aluValid;
  logic        aluHalt;
  logic [11:0] o_res_data;
  logic        o_res_valid;
  logic        i_res_ready;
  logic [3:0]  o_res_count;
  logic [31:0] o_cycle_count;

  logic [11:0] aluRegs [4];
  logic [11:0] modelRegs [4];
  logic [11:0] progImage [64];
  logic [11:0] expQ [$];
  logic [11:0] got [$];
  int          expIssued;
  bit          expOverrun;
  int          checkCount = 0;
  int          passCount  = 0;

  typedef struct packed {
    logic [5:0][11:0] prog;
    logic [3:0]       len;
    logic [3:0]       nOut;
    logic [11:0]      firstOut;
    logic [11:0]      lastOut;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  alu_program_sequencer dut (
    .i_clk             (clk),
    .i_rst             (i_rst),
    .i_prog_we         (i_prog_we),
    .i_prog_addr       (i_prog_addr),
    .i_prog_data       (i_prog_data),
    .i_start           (i_start),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_overrun         (o_overrun),
    .o_alu_instruction (o_alu_instruction),
    .i_alu_out_data    (aluData),
    .i_alu_out_valid   (aluValid),
    .i_alu_halt        (aluHalt),
    .o_res_data        (o_res_data),
    .o_res_valid       (o_res_valid),
    .i_res_ready       (i_res_ready),
    .o_res_count       (o_res_count),
    .o_cycle_count     (o_cycle_count)
  );

  // Behavioural ALU: results are combinational from the presented instruction.
  always_comb begin
    aluValid = 1'b0;
    aluHalt  = 1'b0;
    aluData  = aluRegs[o_alu_instruction[7:6]];
    case (o_alu_instruction[11:8])
      4'hC: aluValid = 1'b1;
      4'hF: begin
        aluValid = 1'b1;
        aluHalt  = 1'b1;
      end
      default: ;
    endcase
  end

  // Behavioural ALU register file, written at the end of each instruction.
  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int r = 0; r < 4; r++) aluRegs[r] <= '0;
    end else begin
      case (o_alu_instruction[11:8])
        4'h1: aluRegs[o_alu_instruction[7:6]] <= {6'd0, o_alu_instruction[5:0]};
        4'h2: aluRegs[o_alu_instruction[7:6]] <= aluRegs[o_alu_instruction[7:6]]
                                               + aluRegs[o_alu_instruction[5:4]];
        default: ;
      endcase
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of host-side inputs, then release the strobes.
  task automatic applyStimulus(input logic we, input logic [5:0] addr,
                               input logic [11:0] data, input logic start);
    i_prog_we   = we;
    i_prog_addr = addr;
    i_prog_data = data;
    i_start     = start;
    tick(1);
    i_prog_we = 1'b0;
    i_start   = 1'b0;
  endtask

  task automatic doReset();
    i_rst       = 1'b1;
    i_prog_we   = 1'b0;
    i_start     = 1'b0;
    i_res_ready = 1'b0;
    tick(2);
    i_rst = 1'b0;
    for (int r = 0; r < 4; r++) modelRegs[r] = '0;
  endtask

  task automatic loadProgram();
    for (int a = 0; a < 64; a++) applyStimulus(1'b1, 6'(a), progImage[a], 1'b0);
  endtask

  task automatic startRun();
    applyStimulus(1'b0, 6'd0, 12'd0, 1'b1);
  endtask

  // Instruction-level interpreter of the current program image.
  task automatic runModel();
    logic [11:0] ins;
    bit          halted;
    expQ.delete();
    expIssued = 0;
    halted    = 1'b0;
    for (int pc = 0; pc < 64 && !halted; pc++) begin
      ins = progImage[pc];
      expIssued++;
      case (ins[11:8])
        4'h1: modelRegs[ins[7:6]] = {6'd0, ins[5:0]};
        4'h2: modelRegs[ins[7:6]] = modelRegs[ins[7:6]] + modelRegs[ins[5:4]];
        4'hC: expQ.push_back(modelRegs[ins[7:6]]);
        4'hF: begin
          expQ.push_back(modelRegs[ins[7:6]]);
          halted = 1'b1;
        end
        default: ;
      endcase
    end
    expOverrun = !halted;
  endtask

  function automatic logic [31:0] expCycles(input int n);
`ifdef SEQ_CYCLE_COUNT_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  // Pop results (with a random ready duty) until DONE and the FIFO is empty.
  task automatic collectResults(input int readyPct, input int budget);
    int n;
    bit finished;
    got.delete();
    n        = 0;
    finished = 1'b0;
    while (!finished && n < budget) begin
      i_res_ready = ($urandom_range(99) < readyPct);
      if (o_res_valid && i_res_ready) got.push_back(o_res_data);
      tick(1);
      n++;
      finished = o_done && !o_res_valid;
    end
    i_res_ready = 1'b0;
    checkOutput("drain_timeout", 32'(finished), 32'd1);
  endtask

  task automatic compareResults(input string name);
    checkOutput({name, "_count"}, 32'(got.size()), 32'(expQ.size()));
    for (int k = 0; k < got.size() && k < expQ.size(); k++) begin
      checkOutput($sformatf("%s_item%0d", name, k), 32'(got[k]), 32'(expQ[k]));
    end
  endtask

  task automatic fillImage(input logic [11:0] pad);
    for (int a = 0; a < 64; a++) progImage[a] = pad;
  endtask

  initial begin
    vecs[0] = '0;
    vecs[0].prog[0] = 12'h103; vecs[0].prog[1] = 12'hC00; vecs[0].prog[2] = 12'hF00;
    vecs[0].len = 4'd3; vecs[0].nOut = 4'd2; vecs[0].firstOut = 12'd3; vecs[0].lastOut = 12'd3;
    vecs[1] = '0;
    vecs[1].prog[0] = 12'h14A; vecs[1].prog[1] = 12'h194; vecs[1].prog[2] = 12'h260;
    vecs[1].prog[3] = 12'hC40; vecs[1].prog[4] = 12'hF80;
    vecs[1].len = 4'd5; vecs[1].nOut = 4'd2; vecs[1].firstOut = 12'd30; vecs[1].lastOut = 12'd20;
    vecs[2] = '0;
    vecs[2].prog[0] = 12'hFC0;
    vecs[2].len = 4'd1; vecs[2].nOut = 4'd1; vecs[2].firstOut = 12'd0; vecs[2].lastOut = 12'd0;
    vecs[3] = '0;
    vecs[3].prog[0] = 12'h1FF; vecs[3].prog[1] = 12'h2F0; vecs[3].prog[2] = 12'h2F0;
    vecs[3].prog[3] = 12'hCC0; vecs[3].prog[4] = 12'hF00;
    vecs[3].len = 4'd5; vecs[3].nOut = 4'd2; vecs[3].firstOut = 12'd252; vecs[3].lastOut = 12'd0;
    vecs[4] = '0;
    vecs[4].prog[0] = 12'h000; vecs[4].prog[1] = 12'hC00; vecs[4].prog[2] = 12'h000;
    vecs[4].prog[3] = 12'hF00;
    vecs[4].len = 4'd4; vecs[4].nOut = 4'd2; vecs[4].firstOut = 12'd0; vecs[4].lastOut = 12'd0;

    i_prog_addr = '0;
    i_prog_data = '0;
    doReset();

    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    checkOutput("rst_done", 32'(o_done), 32'd0);
    checkOutput("rst_overrun", 32'(o_overrun), 32'd0);
    checkOutput("rst_res_valid", 32'(o_res_valid), 32'd0);
    checkOutput("rst_res_count", 32'(o_res_count), 32'd0);
    checkOutput("rst_instr", 32'(o_alu_instruction), 32'h0C00);
    checkOutput("rst_cycles", o_cycle_count, 32'd0);

    $display("[TB] basic program LL/OUT/HALT");
    fillImage(12'hF00);
    progImage[0] = 12'h145; progImage[1] = 12'hC40; progImage[2] = 12'hF40;
    loadProgram();
    runModel();
    startRun();
    tick(2);
    checkOutput("basic_busy_c3", 32'(o_busy), 32'd1);
    checkOutput("basic_done_c3", 32'(o_done), 32'd0);
    tick(1);
    checkOutput("basic_done", 32'(o_done), 32'd1);
    checkOutput("basic_busy", 32'(o_busy), 32'd0);
    checkOutput("basic_overrun", 32'(o_overrun), 32'd0);
    checkOutput("basic_count", 32'(o_res_count), 32'd2);
    checkOutput("basic_cycles", o_cycle_count, expCycles(3));
    collectResults(100, 50);
    checkOutput("basic_first", 32'(got.size() > 0 ? got[0] : 12'hFFF), 32'd5);
    compareResults("basic");

    $display("[TB] overrun without HALT");
    fillImage(12'h145);
    loadProgram();
    startRun();
    tick(63);
    checkOutput("ovr_busy_c64", 32'(o_busy), 32'd1);
    tick(1);
    checkOutput("ovr_done", 32'(o_done), 32'd1);
    checkOutput("ovr_overrun", 32'(o_overrun), 32'd1);
    checkOutput("ovr_count", 32'(o_res_count), 32'd0);
    checkOutput("ovr_instr", 32'(o_alu_instruction), 32'h0C00);
    checkOutput("ovr_cycles", o_cycle_count, expCycles(64));

    $display("[TB] full FIFO stall");
    fillImage(12'hF00);
    progImage[0] = 12'h101; progImage[1] = 12'h142; progImage[2] = 12'h183; progImage[3] = 12'h1C4;
    for (int k = 0; k < 10; k++) progImage[4 + k] = 12'hC00 | 12'((k % 4) << 6);
    progImage[14] = 12'hF80;
    loadProgram();
    runModel();
    startRun();
    tick(12);
    checkOutput("stall_count", 32'(o_res_count), 32'd8);
    checkOutput("stall_busy", 32'(o_busy), 32'd1);
    checkOutput("stall_valid", 32'(o_res_valid), 32'd1);
    tick(3);
    checkOutput("stall_count_hold", 32'(o_res_count), 32'd8);
    checkOutput("stall_busy_hold", 32'(o_busy), 32'd1);
    collectResults(100, 100);
    compareResults("stall");
    checkOutput("stall_expected_len", 32'(expQ.size()), 32'd11);
    checkOutput("stall_cycles", o_cycle_count, expCycles(expIssued + 4));
    checkOutput("stall_overrun", 32'(o_overrun), 32'd0);

    $display("[TB] reset during RUN");
    fillImage(12'hF00);
    progImage[0] = 12'h145; progImage[1] = 12'hC40; progImage[2] = 12'hF40;
    loadProgram();
    startRun();
    tick(1);
    i_rst = 1'b1;
    tick(1);
    i_rst = 1'b0;
    for (int r = 0; r < 4; r++) modelRegs[r] = '0;
    checkOutput("abort_busy", 32'(o_busy), 32'd0);
    checkOutput("abort_done", 32'(o_done), 32'd0);
    checkOutput("abort_valid", 32'(o_res_valid), 32'd0);
    checkOutput("abort_instr", 32'(o_alu_instruction), 32'h0C00);
    runModel();
    startRun();
    collectResults(100, 50);
    compareResults("abort_restart");

    $display("[TB] program write ignored in RUN");
    fillImage(12'hF00);
    progImage[0] = 12'h149; progImage[1] = 12'hC40; progImage[2] = 12'hC40; progImage[3] = 12'hF40;
    loadProgram();
    runModel();
    startRun();
    i_prog_we   = 1'b1;
    i_prog_addr = 6'd1;
    i_prog_data = 12'hF00;
    tick(2);
    i_prog_we = 1'b0;
    collectResults(100, 50);
    compareResults("runwrite");
    runModel();
    startRun();
    collectResults(70, 100);
    compareResults("runwrite_rerun");

    $display("[TB] write and start in the same cycle");
    progImage[0] = 12'h147;
    runModel();
    applyStimulus(1'b1, 6'd0, 12'h147, 1'b1);
    collectResults(100, 50);
    compareResults("wrstart");

    $display("[TB] vector table");
    for (int v = 0; v < 5; v++) begin
      doReset();
      fillImage(12'hF00);
      for (int k = 0; k < 6; k++) begin
        if (k < int'(vecs[v].len)) progImage[k] = vecs[v].prog[k];
      end
      loadProgram();
      startRun();
      collectResults(100, 100);
      checkOutput($sformatf("vec%0d_nout", v), 32'(got.size()), 32'(vecs[v].nOut));
      checkOutput($sformatf("vec%0d_first", v), 32'(got.size() > 0 ? got[0] : 12'hFFF),
                  32'(vecs[v].firstOut));
      checkOutput($sformatf("vec%0d_last", v),
                  32'(got.size() > 0 ? got[got.size() - 1] : 12'hFFF), 32'(vecs[v].lastOut));
      checkOutput($sformatf("vec%0d_overrun", v), 32'(o_overrun), 32'd0);
      checkOutput($sformatf("vec%0d_cycles", v), o_cycle_count, expCycles(int'(vecs[v].len)));
    end

    $display("[TB] randomized programs");
    for (int it = 0; it < 12; it++) begin
      bit allowHalt;
      int pct;
      int op;
      if (it % 2 == 0) doReset();
      allowHalt = ($urandom_range(3) != 0);
      for (int a = 0; a < 64; a++) begin
        op = $urandom_range(19);
        if (op < 6)       progImage[a] = {4'h1, 8'($urandom)};
        else if (op < 9)  progImage[a] = {4'h2, 2'($urandom), 2'($urandom), 4'd0};
        else if (op < 16) progImage[a] = {4'hC, 2'($urandom), 6'd0};
        else if (op < 18) progImage[a] = 12'h000;
        else if (allowHalt) progImage[a] = {4'hF, 2'($urandom), 6'd0};
        else              progImage[a] = {4'hC, 2'($urandom), 6'd0};
      end
      runModel();
      loadProgram();
      pct = $urandom_range(100, 30);
      startRun();
      collectResults(pct, 3000);
      compareResults($sformatf("rand%0d", it));
      checkOutput($sformatf("rand%0d_overrun", it), 32'(o_overrun), 32'(expOverrun));
`ifdef SEQ_CYCLE_COUNT_EN
      checkOutput($sformatf("rand%0d_cycles_min", it), 32'(o_cycle_count >= 32'(expIssued)), 32'd1);
`else
      checkOutput($sformatf("rand%0d_cycles", it), o_cycle_count, 32'd0);
`endif
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
